// File: rtl/bcd_day_counter_gen_if.sv
// Pin bundle between the day counter and whatever drives its buttons and
// observes its displays.
interface bcd_day_counter_gen_if #(
   parameter int DIGITS = 2
);
   logic                rate;
   logic                dir;
   logic                pause;
   logic [4*DIGITS-1:0] count;
   logic                wrap;
   logic                LED0;
   logic [7:0]          HEX0;
   logic [7:0]          HEX1;
   logic [7:0]          HEX2;
   logic [7:0]          HEX3;
   logic [7:0]          HEX4;
   logic [7:0]          HEX5;

   modport master (
      output rate, dir, pause,
      input  count, wrap, LED0, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
   );

   modport slave (
      input  rate, dir, pause,
      output count, wrap, LED0, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
   );
endinterface

// File: rtl/bcd_day_counter_gen.sv
// Up/down BCD counter wrapping between MIN_COUNT and MAX_COUNT, with a
// debounced rate button, pause, wrap LED and registered seven-segment outputs.
module bcd_day_counter_gen #(
   parameter int DIGITS          = 2,
   parameter int MIN_COUNT       = 1,
   parameter int MAX_COUNT       = 99,
   parameter int BASE_DIV        = 10000000,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int BLANK_LZ        = 1
) (
   input logic                  ADC_CLK_10,
   input logic                  reset,
   bcd_day_counter_gen_if.slave bus
);

   localparam int CW = 4 * DIGITS;
   localparam int PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   function automatic logic [CW-1:0] to_bcd(input int v);
      logic [CW-1:0] b;
      int r;
      b = '0;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         b[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   // Walk from the top digit down so 'seen' marks the first nonzero digit.
   function automatic logic [47:0] decode(input logic [CW-1:0] c);
      logic [23:0] pad;
      logic [47:0] h;
      logic        seen;
      pad  = 24'(c);
      h    = '1;
      seen = 1'b0;
      for (int i = 5; i >= 0; i--) begin
         if (i < DIGITS) begin
            seen = seen | (pad[4*i +: 4] != 4'd0);
            if (BLANK_LZ == 0 || i == 0 || seen) h[8*i +: 8] = seg7(pad[4*i +: 4]);
         end
      end
      return h;
   endfunction

   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] c);
      logic [CW-1:0] r;
      logic          carry;
      r     = c;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (c[4*i +: 4] >= 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = c[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] c);
      logic [CW-1:0] r;
      logic          borrow;
      r      = c;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (c[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
            else begin
               r[4*i +: 4] = c[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
      return r;
   endfunction

   localparam logic [CW-1:0] MIN_BCD = to_bcd(MIN_COUNT);
   localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_COUNT);
   localparam logic [47:0]   MIN_HEX = decode(MIN_BCD);

   logic          rate_meta;
   logic          rate_sync;
   logic          rate_level;
   logic [DW-1:0] db_cnt;
   logic [1:0]    rate_sel;
   logic [PW-1:0] prescaler;
   logic [PW-1:0] last_pre;
   logic [CW-1:0] count_q;
   logic          wrap_q;
   logic          led_q;
   logic [47:0]   hex_q;
   logic          differ;
   logic          accept;
   logic          press;
   logic          tick;

   // A press is the accepted level falling; it pre-empts any tick that cycle.
   assign differ   = rate_sync != rate_level;
   assign accept   = differ && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
   assign press    = accept && !rate_sync;
   assign last_pre = PW'((BASE_DIV >> {rate_sel, 1'b0}) - 1);
   assign tick     = !bus.pause && !press && (prescaler == last_pre);

   always_ff @(posedge ADC_CLK_10 or negedge reset) begin
      if (!reset) begin
         rate_meta  <= 1'b1;
         rate_sync  <= 1'b1;
         rate_level <= 1'b1;
         db_cnt     <= '0;
      end else begin
         rate_meta <= bus.rate;
         rate_sync <= rate_meta;
         if (accept) begin
            rate_level <= rate_sync;
            db_cnt     <= '0;
         end else if (differ) begin
            db_cnt <= db_cnt + 1'b1;
         end else begin
            db_cnt <= '0;
         end
      end
   end

   always_ff @(posedge ADC_CLK_10 or negedge reset) begin
      if (!reset) begin
         rate_sel  <= 2'd0;
         prescaler <= '0;
      end else if (press) begin
         rate_sel  <= rate_sel + 2'd1;
         prescaler <= '0;
      end else if (!bus.pause) begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
      end
   end

   // Display registers follow the count register with one cycle of lag.
   always_ff @(posedge ADC_CLK_10 or negedge reset) begin
      if (!reset) begin
         count_q <= MIN_BCD;
         wrap_q  <= 1'b0;
         led_q   <= 1'b0;
         hex_q   <= MIN_HEX;
      end else begin
         wrap_q <= 1'b0;
         hex_q  <= decode(count_q);
         if (tick) begin
            if (!bus.dir) begin
               if (count_q == MAX_BCD) begin
                  count_q <= MIN_BCD;
                  wrap_q  <= 1'b1;
                  led_q   <= ~led_q;
               end else begin
                  count_q <= bcd_inc(count_q);
               end
            end else begin
               if (count_q == MIN_BCD) begin
                  count_q <= MAX_BCD;
                  wrap_q  <= 1'b1;
                  led_q   <= ~led_q;
               end else begin
                  count_q <= bcd_dec(count_q);
               end
            end
         end
      end
   end

   assign bus.count = count_q;
   assign bus.wrap  = wrap_q;
   assign bus.LED0  = led_q;
   assign bus.HEX0  = hex_q[7:0];
   assign bus.HEX1  = hex_q[15:8];
   assign bus.HEX2  = hex_q[23:16];
   assign bus.HEX3  = hex_q[31:24];
   assign bus.HEX4  = hex_q[39:32];
   assign bus.HEX5  = hex_q[47:40];

endmodule
